i2c_timer_arb: RTL
==================

# i2c_timer_arb

Arbiter and sequencer that shares the single 9-bit `timer_n_s` timeout counter among three requesters in the CPLD I2C design, e.g. SCL-stuck-low, bus-idle and clock-stretch supervision. It grants the timer to one requester at a time and drives the timer's `cnt_en`, `cnt_size` and `cnt_pulse`. It returns a one-cycle `done` pulse to the owner on timeout, and guarantees the timer counter is cleared between owners.

## Interface
- `PRESCALE`, 100: `sys_clk` cycles per `tmr_cnt_pulse`; legal range 2..65535.
- `sys_clk` in 1: system clock; all logic on the rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `req` in 3: timer request per requester; level, held until `done` or withdrawn to abort.
- `size0`, `size1`, `size2` in 9 each: timeout length in ticks for each requester; sampled at grant.
- `tmr_timeout` in 1: `timeout` output of the timer instance.
- `gnt` out 3: one-hot registered grant; 0 when no owner.
- `done` out 3: one-cycle registered pulse to the owner when its timeout expires.
- `tmr_cnt_en` out 1: drives timer `cnt_en`.
- `tmr_cnt_size` out 9: drives timer `cnt_size`; holds the latched size of the owner.
- `tmr_cnt_pulse` out 1: drives timer `cnt_pulse`; one-cycle tick.

## Operation
- FSM with three states: IDLE, RUN, GAP. Reset state is IDLE.
- **IDLE**
  - `tmr_cnt_en`=0.
  - If any `req` bit is set, pick the winner, set `gnt` to the winner, latch its size into `tmr_cnt_size`, clear the prescaler, and go to RUN.
  - If no `req` bit is set, stay in IDLE.
- **RUN**
  - `tmr_cnt_en`=1.
  - If `tmr_timeout`=1: pulse `done[owner]` on the next cycle, clear `gnt`, and go to GAP.
  - Otherwise, if `req[owner]`=0: abort. Clear `gnt`, issue no `done`, and go to GAP.
  - If both happen in the same cycle, the timeout wins and `done` is issued.
  - Requests from non-owners are ignored while in RUN; they stay pending.
- **GAP**
  - Exactly one cycle with `tmr_cnt_en`=0, so the timer counter clears.
  - Then go to IDLE.
  - A requester still asserting `req` after its `done` is re-arbitrated as a new request.
- **Arbitration:** round-robin, described under Configuration.
  - Last-owner pointer resets to 2, so `req[0]` wins the first contention.
  - The pointer updates on every grant.
- **Prescaler**
  - 16-bit counter, reset to 0.
  - Increments every cycle and wraps at `PRESCALE`-1.
  - `tmr_cnt_pulse`=1 when the counter equals `PRESCALE`-1.
  - Forced to 0 on the grant cycle.
- **Size 0:** the timer asserts `tmr_timeout` in the first RUN cycle, giving an immediate `done`.
- **`tmr_cnt_size` arithmetic:** latched value only, no arithmetic; 9-bit unsigned.
- **Reset values** (registers return here asynchronously when `sys_rst_n` falls, from any state, mid-run included): `gnt`=0, `done`=0, `tmr_cnt_en`=0, `tmr_cnt_size`=0, `tmr_cnt_pulse`=0, prescaler=0, FSM=IDLE.

## Timing
- Request seen in IDLE at cycle 0:
  - `gnt` and RUN at cycle 1.
  - First tick at cycle `PRESCALE`.
  - Tick k at cycle k·`PRESCALE`.
  - `tmr_timeout` rises at cycle N·`PRESCALE`+1.
  - `done` pulses at cycle N·`PRESCALE`+2, with `gnt`=0 in that same cycle.
- `done` and `gnt` deassertion occur in the same cycle.
- Earliest next grant after any release: GAP cycle plus IDLE cycle, so `gnt` reasserts 2 cycles after it dropped.
- Abort: `req[owner]` low at cycle t gives `gnt`=0 at t+1 and GAP at t+1.

## Configuration
- `TMR_ARB_ROUND_ROBIN_EN`
  - Defined: round-robin. Search starts at last owner+1, modulo 3.
  - Undefined: fixed priority `req[0]` > `req[1]` > `req[2]`; the last-owner pointer is not implemented.

## Test plan
- **Single request:** `PRESCALE`=4, `req`=001, `size0`=3, request at cycle 0. Expect `gnt`=001 at cycle 1, `tmr_cnt_pulse` at cycles 4, 8, 12, `done`=001 at cycle 14, `gnt`=000 at cycle 14.
- **Zero size:** `size1`=0, `req`=010. Expect `gnt` at cycle 1 and `done`=010 at cycle 2.
- **Abort:** `req`=100, `size2`=50, drop `req[2]` at cycle 10. Expect `gnt`=0 at cycle 11, no `done`, `tmr_cnt_en`=0 at cycle 11, and a fresh run starting from count 0 on the next request.
- **Contention:** `req`=111 held continuously, all sizes 1.
  - With `TMR_ARB_ROUND_ROBIN_EN`: grant order 001, 010, 100, 001.
  - Without it: 001 repeatedly.
- **Simultaneous events:** owner drops `req` in the same cycle `tmr_timeout`=1. Expect `done` to pulse anyway.
- **Reset mid-run:** assert `sys_rst_n`=0 during RUN. Expect all outputs 0 immediately, and a pending request granted 1 cycle after release.

Source files
------------

// File: rtl/i2c_timer_arb_if.sv
// Bundle between i2c_timer_arb, its three requesters and the shared timer_n_s instance.
// Handshake: req[i] is a level held by requester i until done[i] (or dropped to abort); gnt is
// one-hot while i owns the timer; done[i] is a one-cycle pulse coinciding with gnt falling.
interface i2c_timer_arb_if;
  logic [2:0] req;
  logic [8:0] size0;
  logic [8:0] size1;
  logic [8:0] size2;
  logic [2:0] gnt;
  logic [2:0] done;
  logic       tmr_timeout;
  logic       tmr_cnt_en;
  logic [8:0] tmr_cnt_size;
  logic       tmr_cnt_pulse;

  modport slave (
    input  req, size0, size1, size2, tmr_timeout,
    output gnt, done, tmr_cnt_en, tmr_cnt_size, tmr_cnt_pulse
  );

  modport master (
    output req, size0, size1, size2, tmr_timeout,
    input  gnt, done, tmr_cnt_en, tmr_cnt_size, tmr_cnt_pulse
  );
endinterface

// File: rtl/i2c_timer_arb.sv
// Shares one timer_n_s timeout counter between three requesters: IDLE -> RUN -> GAP sequencing.
// Define TMR_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority req[0] first.
module i2c_timer_arb #(
  parameter int PRESCALE = 100
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  i2c_timer_arb_if.slave  bus,
  output logic [1:0]      o_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [15:0] LP_PRESC_MAX = 16'(PRESCALE - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_gnt;
  logic [2:0]  w_gnt_nxt;
  logic [2:0]  r_done;
  logic [2:0]  w_done_nxt;
  logic [8:0]  r_size;
  logic [8:0]  w_size_nxt;
  logic [15:0] r_presc;
  logic        w_presc_clr;
  logic [2:0]  w_win;
  logic [8:0]  w_win_size;
  logic        w_grant;

  assign w_grant = (r_state == ST_IDLE) && (bus.req != 3'b000);

`ifdef TMR_ARB_ROUND_ROBIN_EN
  logic [1:0] r_last;

  // Search starts one past the previous owner, wrapping modulo 3.
  always_comb begin
    w_win = 3'b000;
    case (r_last)
      2'd0: begin
        if (bus.req[1])      w_win = 3'b010;
        else if (bus.req[2]) w_win = 3'b100;
        else if (bus.req[0]) w_win = 3'b001;
      end
      2'd1: begin
        if (bus.req[2])      w_win = 3'b100;
        else if (bus.req[0]) w_win = 3'b001;
        else if (bus.req[1]) w_win = 3'b010;
      end
      default: begin
        if (bus.req[0])      w_win = 3'b001;
        else if (bus.req[1]) w_win = 3'b010;
        else if (bus.req[2]) w_win = 3'b100;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_last <= 2'd2;
    end else if (w_grant) begin
      if (w_win[0])      r_last <= 2'd0;
      else if (w_win[1]) r_last <= 2'd1;
      else               r_last <= 2'd2;
    end
  end
`else
  always_comb begin
    w_win = 3'b000;
    if (bus.req[0])      w_win = 3'b001;
    else if (bus.req[1]) w_win = 3'b010;
    else if (bus.req[2]) w_win = 3'b100;
  end
`endif

  always_comb begin
    w_win_size = 9'd0;
    if (w_win[0])      w_win_size = bus.size0;
    else if (w_win[1]) w_win_size = bus.size1;
    else if (w_win[2]) w_win_size = bus.size2;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = 3'b000;
    w_size_nxt  = r_size;
    w_presc_clr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_gnt_nxt   = w_win;
          w_size_nxt  = w_win_size;
          w_presc_clr = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Timeout takes precedence over a same-cycle withdrawal.
        if (bus.tmr_timeout) begin
          w_done_nxt  = r_gnt;
          w_gnt_nxt   = 3'b000;
          w_state_nxt = ST_GAP;
        end else if ((bus.req & r_gnt) == 3'b000) begin
          w_gnt_nxt   = 3'b000;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_gnt_nxt   = 3'b000;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= 3'b000;
      r_done  <= 3'b000;
      r_size  <= 9'd0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_size  <= w_size_nxt;
    end
  end

  // Cleared on grant so tick k of a run lands exactly k*PRESCALE cycles after the request.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_presc <= 16'd0;
    end else if (w_presc_clr || (r_presc == LP_PRESC_MAX)) begin
      r_presc <= 16'd0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  assign bus.gnt           = r_gnt;
  assign bus.done          = r_done;
  assign bus.tmr_cnt_en    = (r_state == ST_RUN);
  assign bus.tmr_cnt_size  = r_size;
  assign bus.tmr_cnt_pulse = (r_presc == LP_PRESC_MAX);
  assign o_state           = r_state;

endmodule
